// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master issues operations; the slave (the adder) reports status and results.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, LSB first,
// WIDTH cycles per operation, one-cycle done pulse with registered results.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_sub_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             c_reg, c_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             carry_reg, carry_next;
    logic             ovf_reg, ovf_next;

    logic [WIDTH-1:0] b_inv;
    logic             bit_sum;
    logic             bit_carry;

    // Subtraction is a + ~b + 1: invert b here, the +1 enters as the initial carry.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign b_inv[gi] = bus.b[gi] ^ bus.sub;
        end
    endgenerate

    assign bit_sum   = opa_reg[0] ^ opb_reg[0] ^ c_reg;
    assign bit_carry = (opa_reg[0] & opb_reg[0]) | (opa_reg[0] & c_reg) | (opb_reg[0] & c_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            opa_reg    <= '0;
            opb_reg    <= '0;
            sum_reg    <= '0;
            c_reg      <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            opa_reg    <= opa_next;
            opb_reg    <= opb_next;
            sum_reg    <= sum_next;
            c_reg      <= c_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            carry_reg  <= carry_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        opa_next    = opa_reg;
        opb_next    = opb_reg;
        sum_next    = sum_reg;
        c_next      = c_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        carry_next  = carry_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    opa_next   = bus.a;
                    opb_next   = b_inv;
                    c_next     = bus.sub;
                    cnt_next   = '0;
                    sum_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                c_next   = bit_carry;
                sum_next = {bit_sum, sum_reg[WIDTH-1:1]};
                opa_next = opa_reg >> 1;
                opb_next = opb_reg >> 1;
                if (cnt_reg == LAST_BIT) begin
                    // On the MSB step c_reg is exactly the carry into the MSB.
                    result_next = {bit_sum, sum_reg[WIDTH-1:1]};
                    carry_next  = bit_carry;
                    ovf_next    = c_reg ^ bit_carry;
                    state_next  = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_reg;
    assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases with literal results,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_serial_add_sub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model state: cycles of busy remaining, done flag and visible outputs.
    int           busy_left = 0;
    bit           done_m    = 1'b0;
    logic [W-1:0] m_res     = '0;
    logic         m_c       = 1'b0;
    logic         m_v       = 1'b0;
    logic [W-1:0] p_res     = '0;
    logic         p_c       = 1'b0;
    logic         p_v       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Plain signed/unsigned arithmetic defines the expected result.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] r, output logic c, output logic v);
        int sa;
        int sb;
        int ex;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ex = s ? (sa - sb) : (sa + sb);
        r  = W'(ex);
        c  = s ? (a >= b) : ((int'(a) + int'(b)) > (2**W - 1));
        v  = (ex > (2**(W-1) - 1)) || (ex < -(2**(W-1)));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                busy_left = 0;
                done_m    = 1'b0;
                m_res     = '0;
                m_c       = 1'b0;
                m_v       = 1'b0;
            end else if (busy_left > 0) begin
                busy_left--;
                done_m = (busy_left == 0);
                if (done_m) begin
                    m_res = p_res;
                    m_c   = p_c;
                    m_v   = p_v;
                end
            end else begin
                done_m = 1'b0;
                if (bus.start) begin
                    busy_left = W;
                    ref_op(bus.a, bus.b, bus.sub, p_res, p_c, p_v);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("busy", 32'(bus.busy), 32'(busy_left > 0));
                check("done", 32'(bus.done), 32'(done_m));
                check("result", 32'(bus.result), 32'(m_res));
                check("carry_out", 32'(bus.carry_out), 32'(m_c));
                check("overflow", 32'(bus.overflow), 32'(m_v));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; busy_cycles counts busy cycles seen first.
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] er, input logic ec, input logic ev);
        int nb;
        issue(a, b, s);
        wait_done(name, nb);
        check({name, "_busy_cycles"}, 32'(nb), 32'(W));
        check({name, "_result"}, 32'(bus.result), 32'(er));
        check({name, "_carry"}, 32'(bus.carry_out), 32'(ec));
        check({name, "_ovf"}, 32'(bus.overflow), 32'(ev));
        $display("op %s: a=%02h b=%02h sub=%0d -> result=%02h carry=%0d ovf=%0d",
                 name, a, b, s, bus.result, bus.carry_out, bus.overflow);
    endtask

    initial begin
        int nb;
        int gap;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);

        run_op("add", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        run_op("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_neg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_pos", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start pulse mid-RUN must be ignored; then back-to-back start in DONE.
        issue(8'h35, 8'h4A, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h66;
        bus.sub   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignore_start", nb);
        check("ignore_start_result", 32'(bus.result), 32'h7F);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        bus.sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        gap = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) check("hold_result", 32'(bus.result), 32'h7F);
            if (bus.done) begin
                gap = k;
                break;
            end
        end
        check("b2b_gap", 32'(gap), 32'(W + 1));
        check("b2b_result", 32'(bus.result), 32'h30);
        $display("op b2b: gap=%0d result=%02h", gap, bus.result);

        // Reset after four processed bits aborts the operation.
        issue(8'h12, 8'h34, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_carry", 32'(bus.carry_out), 32'd0);
        check("abort_ovf", 32'(bus.overflow), 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        $display("op abort: outputs cleared, no done");
        run_op("after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Random traffic, including starts in every state and rare resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.sub   = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
